seg_scan_controller: RTL and testbench

Time-multiplexed scan controller for the multi-digit seven-segment display. It holds one 5-bit display code per digit, drives a single shared `seven_segs_decoder` with the current digit's code, and walks an active-low one-hot anode bus across the digits. A blanking gap at the start of every slot suppresses ghosting. The block also provides per-digit blinking and tear-free frame-synchronous updates through a valid/ready load port.

---
 rtl/seg_scan_controller.sv | 150 +++++++++++++++
 tb/tb_seg_scan_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Time-multiplexed seven-segment scan controller: walks an active-low anode bus
// across the digits with a blanking gap per slot, blinking and frame-synchronous loads.
module seg_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GAP_CYCLES   = 500,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_valid,
   input  logic [5*NUM_DIGITS-1:0] load_data,
   output logic                    load_ready,
   input  logic                    blink_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [4:0]              digit_code,
   output logic [NUM_DIGITS-1:0]   anode_n,
   output logic                    frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int KW = $clog2(NUM_DIGITS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] C_GAP  = CW'(GAP_CYCLES);
   localparam logic [KW-1:0] K_LAST = KW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [4:0]    BLANK  = 5'd23;

   typedef enum logic {ST_GAP = 1'b0, ST_SHOW = 1'b1} slot_state_t;

   slot_state_t             state_r;
   slot_state_t             state_next_s;
   logic [CW-1:0]           c_r;
   logic [CW-1:0]           c_next_s;
   logic [KW-1:0]           k_r;
   logic [KW-1:0]           k_next_s;
   logic [FW-1:0]           fcnt_r;
   logic                    phase_r;
   logic [4:0]              active_r      [NUM_DIGITS];
   logic [4:0]              active_next_s [NUM_DIGITS];
   logic [4:0]              pending_r     [NUM_DIGITS];
   logic                    pend_r;
   logic                    pend_next_s;
   logic                    boundary_s;
   logic                    transfer_s;
   logic [4:0]              code_next_s;
   logic [4:0]              code_r;
   logic [NUM_DIGITS-1:0]   anode_r;
   logic                    frame_done_r;
   logic                    ready_r;

   // Next-state logic: slot counters, slot FSM, commit of the pending set and next code
   always_comb begin
      boundary_s   = (c_r == C_LAST) && (k_r == K_LAST);
      transfer_s   = load_valid && !pend_r;
      c_next_s     = '0;
      k_next_s     = k_r;
      state_next_s = state_r;
      pend_next_s  = pend_r;
      code_next_s  = BLANK;
      if (c_r == C_LAST) begin
         c_next_s = '0;
         k_next_s = (k_r == K_LAST) ? '0 : k_r + KW'(1);
      end else begin
         c_next_s = c_r + CW'(1);
         k_next_s = k_r;
      end
      case (state_r)
         ST_GAP:  state_next_s = (c_next_s >= C_GAP) ? ST_SHOW : ST_GAP;
         ST_SHOW: state_next_s = (c_next_s < C_GAP) ? ST_GAP : ST_SHOW;
         default: state_next_s = ST_GAP;
      endcase
      // A boundary commit always wins; a transfer is impossible while pend_r is set
      if (boundary_s && pend_r) begin
         pend_next_s = 1'b0;
      end else if (transfer_s) begin
         pend_next_s = 1'b1;
      end else begin
         pend_next_s = pend_r;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         active_next_s[i] = (boundary_s && pend_r) ? pending_r[i] : active_r[i];
      end
      code_next_s = active_next_s[k_next_s];
   end

   // Slot FSM, handshake, blink timing and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= (GAP_CYCLES == 0) ? ST_SHOW : ST_GAP;
         c_r          <= '0;
         k_r          <= '0;
         fcnt_r       <= '0;
         phase_r      <= 1'b0;
         pend_r       <= 1'b0;
         ready_r      <= 1'b1;
         code_r       <= BLANK;
         anode_r      <= {NUM_DIGITS{1'b1}};
         frame_done_r <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            active_r[i]  <= BLANK;
            pending_r[i] <= 5'd0;
         end
      end else begin
         state_r      <= state_next_s;
         c_r          <= c_next_s;
         k_r          <= k_next_s;
         pend_r       <= pend_next_s;
         ready_r      <= !pend_next_s;
         code_r       <= code_next_s;
         frame_done_r <= (c_next_s == C_LAST) && (k_next_s == K_LAST);
         case (state_next_s)
            ST_GAP:  anode_r <= {NUM_DIGITS{1'b1}};
            ST_SHOW: anode_r <= ~(NUM_DIGITS'(1) << k_next_s);
            default: anode_r <= {NUM_DIGITS{1'b1}};
         endcase
         for (int i = 0; i < NUM_DIGITS; i++) begin
            active_r[i] <= active_next_s[i];
            if (transfer_s) begin
               pending_r[i] <= load_data[5*i +: 5];
            end else begin
               pending_r[i] <= pending_r[i];
            end
         end
         if (!blink_en) begin
            fcnt_r  <= '0;
            phase_r <= 1'b0;
         end else if (boundary_s) begin
            if (fcnt_r == F_LAST) begin
               fcnt_r  <= '0;
               phase_r <= !phase_r;
            end else begin
               fcnt_r  <= fcnt_r + FW'(1);
               phase_r <= phase_r;
            end
         end else begin
            fcnt_r  <= fcnt_r;
            phase_r <= phase_r;
         end
      end
   end

   // The mask acts in the same cycle, so it gates the registered code directly
   assign digit_code = (phase_r && blink_mask[k_r]) ? BLANK : code_r;
   assign anode_n    = anode_r;
   assign frame_done = frame_done_r;
   assign load_ready = ready_r;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller: directed vector table, corner-case
// sequences and a randomized run against a cycle-count based reference model.
module tb_seg_scan_controller;

   localparam int N  = 4;
   localparam int R  = 8;
   localparam int G  = 2;
   localparam int BF = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             load_valid;
   logic [5*N-1:0]   load_data;
   logic             load_ready;
   logic             blink_en;
   logic [N-1:0]     blink_mask;
   logic [4:0]       digit_code;
   logic [N-1:0]     anode_n;
   logic             frame_done;

   int checks = 0;
   int errors = 0;

   seg_scan_controller #(
      .NUM_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .blink_en(blink_en), .blink_mask(blink_mask),
      .digit_code(digit_code), .anode_n(anode_n), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Reference model: position comes from the cycle count since reset
   int         t;
   logic [4:0] m_act  [N];
   logic [4:0] m_pend [N];
   bit         m_has_pend;
   int         m_fcnt;
   bit         m_phase;

   typedef struct {
      int         cyc;
      logic [N-1:0] anode;
      logic [4:0] code;
      logic       fd;
      logic       ready;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, t, act, exp);
      end
   endtask

   task automatic model_reset();
      t = 0;
      m_has_pend = 1'b0;
      m_fcnt = 0;
      m_phase = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_act[i]  = 5'd23;
         m_pend[i] = 5'd0;
      end
   endtask

   task automatic sample(input string tag);
      int c;
      int k;
      logic [N-1:0] ea;
      logic [4:0] ec;
      @(negedge clk);
      c  = t % R;
      k  = (t / R) % N;
      ea = (c < G) ? {N{1'b1}} : ~(N'(1) << k);
      ec = (m_phase && blink_mask[k]) ? 5'd23 : m_act[k];
      chk({tag, ".anode"}, 32'(anode_n), 32'(ea));
      chk({tag, ".code"}, 32'(digit_code), 32'(ec));
      chk({tag, ".frame_done"}, 32'(frame_done), 32'(c == R - 1 && k == N - 1));
      chk({tag, ".ready"}, 32'(load_ready), 32'(!m_has_pend));
   endtask

   task automatic advance();
      bit boundary;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         boundary = (t % R == R - 1) && ((t / R) % N == N - 1);
         if (boundary && m_has_pend) begin
            m_act = m_pend;
            m_has_pend = 1'b0;
         end else if (load_valid && !m_has_pend) begin
            for (int i = 0; i < N; i++) m_pend[i] = load_data[5*i +: 5];
            m_has_pend = 1'b1;
         end
         if (!blink_en) begin
            m_fcnt = 0;
            m_phase = 1'b0;
         end else if (boundary) begin
            if (m_fcnt == BF - 1) begin
               m_fcnt = 0;
               m_phase = !m_phase;
            end else begin
               m_fcnt++;
            end
         end
         t++;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      load_valid = 1'b0;
      load_data = '0;
      blink_en = 1'b0;
      blink_mask = '0;
      advance();
      advance();
      rst_n = 1'b1;
   endtask

   initial begin
      int vi;
      int f;
      tbl[0]  = '{0,  4'hF, 5'd23, 1'b0, 1'b1};
      tbl[1]  = '{1,  4'hF, 5'd23, 1'b0, 1'b1};
      tbl[2]  = '{2,  4'hE, 5'd23, 1'b0, 1'b1};
      tbl[3]  = '{5,  4'hE, 5'd23, 1'b0, 1'b1};
      tbl[4]  = '{6,  4'hE, 5'd23, 1'b0, 1'b0};
      tbl[5]  = '{7,  4'hE, 5'd23, 1'b0, 1'b0};
      tbl[6]  = '{8,  4'hF, 5'd23, 1'b0, 1'b0};
      tbl[7]  = '{10, 4'hD, 5'd23, 1'b0, 1'b0};
      tbl[8]  = '{15, 4'hD, 5'd23, 1'b0, 1'b0};
      tbl[9]  = '{31, 4'h7, 5'd23, 1'b1, 1'b0};
      tbl[10] = '{32, 4'hF, 5'd4,  1'b0, 1'b1};
      tbl[11] = '{33, 4'hF, 5'd4,  1'b0, 1'b0};
      tbl[12] = '{34, 4'hE, 5'd4,  1'b0, 1'b0};
      tbl[13] = '{39, 4'hE, 5'd4,  1'b0, 1'b0};
      tbl[14] = '{40, 4'hF, 5'd3,  1'b0, 1'b0};
      tbl[15] = '{63, 4'h7, 5'd1,  1'b1, 1'b0};
      tbl[16] = '{64, 4'hF, 5'd5,  1'b0, 1'b1};

      model_reset();
      do_reset();

      // Load at cycle 5, then a second offer held until it is accepted
      vi = 0;
      for (int cyc = 0; cyc <= 64; cyc++) begin
         load_valid = (cyc >= 5 && cyc <= 32);
         load_data  = (cyc == 5) ? {5'd1, 5'd2, 5'd3, 5'd4} : {5'd5, 5'd5, 5'd5, 5'd5};
         sample("table");
         if (vi < 17 && tbl[vi].cyc == cyc) begin
            chk("vec.anode", 32'(anode_n), 32'(tbl[vi].anode));
            chk("vec.code", 32'(digit_code), 32'(tbl[vi].code));
            chk("vec.frame_done", 32'(frame_done), 32'(tbl[vi].fd));
            chk("vec.ready", 32'(load_ready), 32'(tbl[vi].ready));
            vi++;
         end
         advance();
      end
      chk("vec.all_applied", 32'(vi), 32'd17);

      // Load offered on the frame-boundary cycle commits one frame later
      do_reset();
      for (int cyc = 0; cyc <= 64; cyc++) begin
         load_valid = (cyc == 31);
         load_data  = {5'd6, 5'd7, 5'd8, 5'd9};
         sample("late_load");
         if (cyc == 31) chk("late.ready31", 32'(load_ready), 32'd1);
         if (cyc == 32) chk("late.ready32", 32'(load_ready), 32'd0);
         if (cyc == 40) chk("late.blank40", 32'(digit_code), 32'd23);
         if (cyc == 63) chk("late.blank63", 32'(digit_code), 32'd23);
         if (cyc == 64) chk("late.show64", 32'(digit_code), 32'd9);
         advance();
      end

      // Blinking digit 1, with a same-cycle mask change inside an off frame
      do_reset();
      for (int cyc = 0; cyc < 7 * 32; cyc++) begin
         f = cyc / 32;
         load_valid = (cyc == 0);
         load_data  = {5'd1, 5'd2, 5'd3, 5'd4};
         blink_en   = (cyc >= 32);
         blink_mask = (cyc == 108) ? 4'b0000 : 4'b0010;
         sample("blink");
         if (cyc >= 32 && cyc % 32 == 11)
            chk("blink.d1", 32'(digit_code), (f == 3 || f == 4) ? 32'd23 : 32'd3);
         if (cyc >= 32 && cyc % 32 == 20) chk("blink.d2", 32'(digit_code), 32'd2);
         if (cyc == 108) chk("blink.mask_same_cycle", 32'(digit_code), 32'd3);
         if (cyc == 109) chk("blink.mask_restore", 32'(digit_code), 32'd23);
         advance();
      end

      // Reset during slot 2 with data pending
      do_reset();
      for (int cyc = 0; cyc < 18; cyc++) begin
         load_valid = (cyc == 3);
         load_data  = {5'd7, 5'd7, 5'd7, 5'd7};
         sample("midrst");
         advance();
      end
      load_valid = 1'b0;
      chk("midrst.pending", 32'(load_ready), 32'd0);
      rst_n = 1'b0;
      sample("midrst");
      advance();
      rst_n = 1'b1;
      sample("midrst");
      chk("midrst.anode", 32'(anode_n), 32'hF);
      chk("midrst.code", 32'(digit_code), 32'd23);
      chk("midrst.ready", 32'(load_ready), 32'd1);
      advance();
      for (int cyc = 0; cyc < 80; cyc++) begin
         sample("midrst");
         chk("midrst.no_stale", 32'(digit_code == 5'd7), 32'd0);
         advance();
      end

      // Randomized traffic against the model
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         load_valid = ($urandom_range(0, 3) == 0);
         load_data  = 20'($urandom);
         if ($urandom_range(0, 199) == 0) blink_en = !blink_en;
         if ($urandom_range(0, 9) == 0) blink_mask = 4'($urandom);
         rst_n = ($urandom_range(0, 999) != 0);
         sample("rnd");
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
